// File: rtl/half_exp_arbiter.sv
// Round-robin front end that shares one fixed-latency half_base2_exp unit among NREQ requesters. The result returns LAT+2 cycles after the handshake.
// There is no response backpressure, and the unit never stalls. Defining HALF_EXP_ARB_STATS_EN adds per-requester grant counters.
module half_exp_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [15:0]          resp_c,
  output logic                 exp_in_valid,
  output logic [15:0]          exp_a,
  input  logic                 exp_out_valid,
  input  logic [15:0]          exp_c,
  output logic                 busy,
  output logic                 err_orphan
`ifdef HALF_EXP_ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [16*NREQ-1:0]   stat_grants
`endif
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] idx;
  logic           hs;
  logic [15:0]    sel_a;
  logic [IDW-1:0] issue_id;
  logic [LAT-1:0] tag_v;
  logic [IDW-1:0] tag_id [LAT];
  logic           tail_v;
  logic [IDW-1:0] tail_id;
  logic [NREQ-1:0] tail_onehot;

  // First valid requester at or after the pointer, wrapping at NREQ.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    idx       = '0;
    hs        = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr) + 32'(k)) % NREQ);
      if (!hs && req_valid[idx]) begin
        hs             = 1'b1;
        grant_id       = idx;
        req_ready[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == IDW'(k)) sel_a = req_a[16*k +: 16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      exp_in_valid <= 1'b0;
      exp_a        <= '0;
      issue_id     <= '0;
    end else begin
      exp_in_valid <= hs;
      if (hs) begin
        ptr      <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
        exp_a    <= sel_a;
        issue_id <= grant_id;
      end
    end
  end

  // Tag shift register; its tail lines up with the unit's out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= exp_in_valid;
      tag_id[0] <= issue_id;
      for (int k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign tail_v  = tag_v[LAT-1];
  assign tail_id = tag_id[LAT-1];

  always_comb begin
    tail_onehot          = '0;
    tail_onehot[tail_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_c     <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (exp_out_valid && tail_v) begin
        resp_valid <= tail_onehot;
        resp_c     <= exp_c;
      end else begin
        resp_valid <= '0;
      end
      // A valid/tag disagreement means the unit latency is not LAT.
      if (exp_out_valid != tail_v) err_orphan <= 1'b1;
    end
  end

  assign busy = exp_in_valid | (|tag_v) | (|resp_valid);

`ifdef HALF_EXP_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (stat_clr) begin
          stat_grants[16*k +: 16] <= '0;
        end else if (req_ready[k] && stat_grants[16*k +: 16] != 16'hFFFF) begin
          stat_grants[16*k +: 16] <= stat_grants[16*k +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/half_exp_arbiter.md
Name: half_exp_arbiter

Overview:
- Shares one half_base2_exp unit (fixed-latency, no backpressure, no tag) among NREQ requesters.
- Round-robin arbitration issues at most one operand per cycle to the unit.
- Carries a requester-ID tag pipeline matched to the unit latency and routes each result back to its requester.
- Sits between the vector/activation front-ends and the single shared exp datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LAT, 4, cycles from unit in_valid to unit out_valid (>=1)
- IDW, $clog2(NREQ), tag width (derived, do not override)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester operand valid
- req_a  input  16*NREQ  per-requester half-precision operand; requester i on bits [16*i+15:16*i]
- req_ready  output  NREQ  one-hot grant; a handshake occurs when req_valid[i] and req_ready[i] are both high
- resp_valid  output  NREQ  one-hot result strobe, single cycle
- resp_c  output  16  result value, meaningful only while resp_valid is non-zero
- exp_in_valid  output  1  drives unit in_valid
- exp_a  output  16  drives unit a
- exp_out_valid  input  1  from unit out_valid
- exp_c  input  16  from unit c
- busy  output  1  high while any operation is in flight
- err_orphan  output  1  sticky tag/result mismatch flag

Behaviour:
- Reset (async assert, sync deassert external):
  - All outputs 0.
  - RR pointer = 0.
  - Tag pipeline cleared.
  - err_orphan cleared.
- Arbitration (combinational):
  - Search req_valid starting at the pointer, ascending, wrapping at NREQ.
  - The first set bit gets req_ready; otherwise req_ready = 0.
  - Requesters may not depend on req_ready to raise req_valid.
- Pointer update:
  - On a handshake with requester g, the pointer becomes (g+1) mod NREQ on the next edge.
  - With no handshake the pointer is unchanged.
- Issue stage (registered):
  - exp_in_valid <= handshake.
  - exp_a <= req_a[g].
  - issue_id <= g.
  - exp_a holds its previous value when there is no handshake.
  - Handshake at cycle T gives exp_in_valid high at T+1.
- Tag pipeline:
  - LAT-deep shift register of {valid, id}.
  - Stage 0 loads {exp_in_valid, issue_id} each cycle.
  - Stage LAT-1 output aligns with exp_out_valid.
  - Advances every cycle unconditionally; the unit cannot stall.
- Response stage (registered):
  - When exp_out_valid and the tail tag is valid: resp_valid <= one-hot(tail id) and resp_c <= exp_c.
  - Otherwise resp_valid <= 0 and resp_c holds.
  - End-to-end latency, handshake to resp_valid: LAT+2 cycles.
  - Requesters must accept responses; there is no response backpressure.
- Throughput: one operation per cycle sustained; a single active requester gets every cycle.
- busy = exp_in_valid OR any tag valid OR any resp_valid bit.
- err_orphan:
  - Set when exp_out_valid differs from the tail tag valid (unit latency not equal to LAT).
  - Cleared only by reset.
  - On an orphan, resp_valid stays 0.
- Reset mid-operation: in-flight tags are discarded. Results the unit emits after reset with an empty tag pipeline set err_orphan. The integration must reset the unit together with this block.
- Simultaneous handshake and response for the same requester is legal and independent.

Optional Feature:
- HALF_EXP_ARB_STATS_EN
- Defined:
  - Adds output stat_grants, 16*NREQ bits: one 16-bit saturating counter per requester, incremented on each handshake, stopping at 0xFFFF.
  - Adds input stat_clr, 1 bit: synchronous clear of all counters.
  - Counters reset to 0.
- Undefined: neither port exists and there is no counter logic. Arbitration and timing are identical either way.

Test Plan:
- Single requester: req_valid = 0001, req_a[0] = 0x3C00, unit model LAT = 4 -> req_ready = 0001 same cycle; exp_in_valid at T+1; resp_valid = 0001 with resp_c = 0x4000 at T+6.
- All four requesting continuously, operands 0x0000/0x3C00/0x4000/0xBC00 -> grants 0,1,2,3,0,...; responses in the same order with 0x3C00/0x4000/0x4400/0x3800, one per cycle, no gaps.
- Pointer wrap: grant requester 3, then req_valid = 1001 -> next grant 0, then 3.
- Mismatch: unit model with latency 5 while LAT = 4 -> err_orphan rises at the first result, no resp_valid; stays set until rst_n is asserted.
- Reset mid-flight: assert rst_n low with 3 operations in flight -> all outputs 0 asynchronously; after release no resp_valid and busy = 0 (unit also reset).
- With HALF_EXP_ARB_STATS_EN: 70000 grants to requester 1 -> stat_grants[31:16] = 0xFFFF; pulse stat_clr -> 0.
